// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects one board switch/button bit, with a wrapping press counter.
// Optional auto-repeat of press_pulse while held: define INPUT_CONDITIONER_AUTO_REPEAT_EN.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  output logic       level_out,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be in 1..65535");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("input_conditioner: REPEAT_CYCLES must be at least 2");
  end

  logic             in_bit;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             flip;
  logic             repeat_hit;

  // Polarity is normalized before the synchronizer so a released KEY matches the reset value.
  assign in_bit = raw_in ^ ACTIVE_LOW;

  // NOTE: sequential state uses non-blocking assignments so sync2 takes the old sync1, not the new one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
    end
  end

  assign flip = (sync2 != level_out) && (cnt == CNT_LAST);

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
  localparam int                RCNT_W    = $clog2(REPEAT_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

  logic [RCNT_W-1:0] rcnt;

  // A debounced edge takes priority over a repeat, so press and release never coincide.
  assign repeat_hit = level_out && !flip && (rcnt == RCNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
    end else if (flip || !level_out || rcnt == RCNT_LAST) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      level_out     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync2 == level_out) begin
        cnt <= '0;
      end else if (flip) begin
        level_out     <= sync2;
        cnt           <= '0;
        press_pulse   <= sync2;
        release_pulse <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (repeat_hit) begin
        press_pulse <= 1'b1;
      end
    end
  end

  // Counts the registered pulse, so the count lags press_pulse by one cycle and wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_count <= 8'd0;
    end else if (press_pulse) begin
      press_count <= press_count + 8'd1;
    end
  end

endmodule
